wireless_telemetry: RTL and testbench

Parametrised Bluetooth command/response engine between the UART (RN41 link) and the assistance datapath. Decodes command bytes from the phone, snapshots the selected sensor channel (speed, inclination, heart rate, etc.), and streams a framed multi-byte reply through the UART transmit handshake. Supersedes the single-byte, two-channel handler. Adds:
- N channels
- wide data
- ping and error replies
- one-deep command queue
- error/overrun counters

---
 rtl/wireless_telemetry.sv | 207 ++++++++++++++++++++
 tb/tb_wireless_telemetry.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wireless_telemetry.sv
// Bluetooth command/response engine: decodes command bytes from the phone,
// snapshots the addressed telemetry channel and streams a framed reply out
// through the UART transmit handshake, with a one-deep pending command slot.
module wireless_telemetry #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       received,
    input  logic [7:0]                 rx_byte,
    input  logic                       recv_error,
    input  logic                       is_transmitting,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    output logic                       transmit,
    output logic [7:0]                 tx_byte,
    output logic                       busy,
    output logic [7:0]                 err_count,
    output logic [7:0]                 ovr_count
);

    localparam int         NB            = (DATA_W + 7) / 8;
    localparam int         SNAP_W        = NB * 8;
    localparam logic [2:0] LAST_DATA_IDX = 3'(NB);
    localparam logic [7:0] MAX_CMD       = 8'(NUM_CH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [7:0]          pend_q, pend_d;
    logic                pend_valid_q, pend_valid_d;
    logic [SNAP_W-1:0]   snap_q, snap_d;
    logic [2:0]          idx_q, idx_d;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic [7:0]          err_q, err_d;
    logic [7:0]          ovr_q, ovr_d;

    logic                accept;
    logic                cmd_is_read;
    logic                cmd_is_bad;
    logic                frame_last;
    logic                frame_end;
    logic                pop;
    logic                direct;
    logic                enter_load;
    logic                bad_done;
    logic [7:0]          load_cmd;
    logic [7:0]          frame_byte;
    logic [2:0]          byte_idx;
    logic [DATA_W-1:0]   sel_data;

    // Classify the active command and find the frame-boundary events; a frame
    // ending with nothing pending may take a new command straight into LOAD.
    always_comb begin
        accept      = received && !recv_error;
        cmd_is_read = (cmd_q != 8'd0) && (cmd_q <= MAX_CMD);
        cmd_is_bad  = (cmd_q != 8'd0) && !cmd_is_read;
        frame_last  = cmd_is_read ? (idx_q == LAST_DATA_IDX) : (idx_q == 3'd0);
        frame_end   = (state_q == WAIT_DONE) && !is_transmitting && frame_last;
        pop         = frame_end && pend_valid_q;
        direct      = frame_end && !pend_valid_q && accept;
        enter_load  = ((state_q == IDLE) && accept) || pop || direct;
        load_cmd    = pop ? pend_q : rx_byte;
    end

    // Select the channel addressed by the command about to enter LOAD.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (load_cmd == 8'(k + 1)) begin
                sel_data = ch_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Frame byte presented on the upcoming SEND: header first, data MSB first.
    always_comb begin
        byte_idx   = (state_q == WAIT_DONE) ? (idx_q + 3'd1) : idx_q;
        frame_byte = 8'hEE;
        if (cmd_q == 8'd0) begin
            frame_byte = 8'h55;
        end else if (cmd_is_read) begin
            if (byte_idx == 3'd0) begin
                frame_byte = {4'hA, cmd_q[3:0]};
            end else begin
                for (int b = 0; b < NB; b++) begin
                    if (byte_idx == 3'(NB - b)) begin
                        frame_byte = snap_q[b*8 +: 8];
                    end
                end
            end
        end
    end

    // FSM next state, snapshot capture, pending slot and saturating counters.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        snap_d       = snap_q;
        idx_d        = idx_q;
        tx_byte_d    = tx_byte_q;
        err_d        = err_q;
        ovr_d        = ovr_q;
        bad_done     = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            LOAD: begin
                // Hold off while a byte from before a reset is still shifting.
                if (!is_transmitting) begin
                    state_d   = SEND;
                    tx_byte_d = frame_byte;
                    bad_done  = cmd_is_bad;
                end
            end
            SEND: begin
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (is_transmitting) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!is_transmitting) begin
                    if (!frame_last) begin
                        state_d   = SEND;
                        idx_d     = idx_q + 3'd1;
                        tx_byte_d = frame_byte;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_load) begin
            state_d = LOAD;
            cmd_d   = load_cmd;
            snap_d  = SNAP_W'(sel_data);
            idx_d   = 3'd0;
        end

        if (pop) begin
            pend_valid_d = 1'b0;
        end

        if ((state_q != IDLE) && accept && !direct) begin
            if (!pend_valid_q || pop) begin
                pend_d       = rx_byte;
                pend_valid_d = 1'b1;
            end else if (ovr_q != 8'hFF) begin
                ovr_d = ovr_q + 8'd1;
            end
        end

        if ((recv_error || bad_done) && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    // State register with synchronous reset that also abandons any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cmd_q        <= 8'd0;
            pend_q       <= 8'd0;
            pend_valid_q <= 1'b0;
            snap_q       <= '0;
            idx_q        <= 3'd0;
            tx_byte_q    <= 8'd0;
            err_q        <= 8'd0;
            ovr_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            snap_q       <= snap_d;
            idx_q        <= idx_d;
            tx_byte_q    <= tx_byte_d;
            err_q        <= err_d;
            ovr_q        <= ovr_d;
        end
    end

    assign transmit  = (state_q == SEND);
    assign busy      = (state_q != IDLE);
    assign tx_byte   = tx_byte_q;
    assign err_count = err_q;
    assign ovr_count = ovr_q;

endmodule

// File: tb/tb_wireless_telemetry.sv
// Testbench for wireless_telemetry: two instances (4x16 and 2x12), each with
// a behavioural UART model, checked against a frame model built from the
// command rules with plain arithmetic.
module tb_wireless_telemetry;

    localparam int NCH_A = 4;
    localparam int DW_A  = 16;
    localparam int NCH_B = 2;
    localparam int DW_B  = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic                   rcv_a = 1'b0, rerr_a = 1'b0, istx_a = 1'b0;
    logic [7:0]             rx_a = 8'd0;
    logic [NCH_A*DW_A-1:0]  ch_a = '0;
    logic                   tr_a, busy_a;
    logic [7:0]             txb_a, err_a, ovr_a;

    logic                   rcv_b = 1'b0, rerr_b = 1'b0, istx_b = 1'b0;
    logic [7:0]             rx_b = 8'd0;
    logic [NCH_B*DW_B-1:0]  ch_b = '0;
    logic                   tr_b, busy_b;
    logic [7:0]             txb_b, err_b, ovr_b;

    int checks = 0;
    int errors = 0;
    int cnt_a = 0;
    int cnt_b = 0;
    int err_exp = 0;
    int ovr_exp = 0;
    logic [7:0] cap_a[$];
    logic [7:0] cap_b[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    wireless_telemetry #(.NUM_CH(NCH_A), .DATA_W(DW_A)) dut (
        .clk(clk), .rst(rst), .received(rcv_a), .rx_byte(rx_a),
        .recv_error(rerr_a), .is_transmitting(istx_a), .ch_data(ch_a),
        .transmit(tr_a), .tx_byte(txb_a), .busy(busy_a),
        .err_count(err_a), .ovr_count(ovr_a)
    );

    wireless_telemetry #(.NUM_CH(NCH_B), .DATA_W(DW_B)) dut12 (
        .clk(clk), .rst(rst), .received(rcv_b), .rx_byte(rx_b),
        .recv_error(rerr_b), .is_transmitting(istx_b), .ch_data(ch_b),
        .transmit(tr_b), .tx_byte(txb_b), .busy(busy_b),
        .err_count(err_b), .ovr_count(ovr_b)
    );

    // UART model A: captures each transmitted byte, shifts it for a random
    // number of cycles, and flags any transmit pulse while still shifting.
    always @(negedge clk) begin
        if (tr_a) begin
            checks++;
            if (istx_a) begin
                errors++;
                $display("[TB] FAIL uart_overlap_a: transmit=1 with is_transmitting=%0b, required 0", istx_a);
            end
            cap_a.push_back(txb_a);
            istx_a = 1'b1;
            cnt_a  = $urandom_range(2, 5);
        end else if (cnt_a > 0) begin
            cnt_a--;
            if (cnt_a == 0) istx_a = 1'b0;
        end
    end

    // UART model B, same behaviour for the 12-bit instance.
    always @(negedge clk) begin
        if (tr_b) begin
            checks++;
            if (istx_b) begin
                errors++;
                $display("[TB] FAIL uart_overlap_b: transmit=1 with is_transmitting=%0b, required 0", istx_b);
            end
            cap_b.push_back(txb_b);
            istx_b = 1'b1;
            cnt_b  = $urandom_range(2, 5);
        end else if (cnt_b > 0) begin
            cnt_b--;
            if (cnt_b == 0) istx_b = 1'b0;
        end
    end

    // Reference frame for one command, appended to exp_q.
    function automatic void build_expected(input logic [7:0] cmd, input logic [63:0] data,
                                           input int nch, input int dw);
        logic [63:0] val;
        int nb;
        if (cmd == 8'd0) begin
            exp_q.push_back(8'h55);
        end else if (int'(cmd) <= nch) begin
            val = (data >> ((int'(cmd) - 1) * dw)) & ((64'd1 << dw) - 64'd1);
            nb  = (dw + 7) / 8;
            exp_q.push_back({4'hA, cmd[3:0]});
            for (int i = nb - 1; i >= 0; i--) exp_q.push_back(8'(val >> (8 * i)));
        end else begin
            exp_q.push_back(8'hEE);
        end
    endfunction

    function automatic bit is_bad_a(input logic [7:0] cmd);
        return int'(cmd) > NCH_A;
    endfunction

    function automatic void bump_err();
        err_exp = (err_exp < 255) ? err_exp + 1 : 255;
    endfunction

    task automatic send_a(input logic [7:0] cmd, input logic with_err);
        rcv_a  = 1'b1;
        rx_a   = cmd;
        rerr_a = with_err;
        @(negedge clk);
        rcv_a  = 1'b0;
        rerr_a = 1'b0;
    endtask

    task automatic wait_idle(input bit which_b, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!which_b && !busy_a && !istx_a) begin ok = 1'b1; return; end
            if (which_b && !busy_b && !istx_b) begin ok = 1'b1; return; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tr_a !== 1'b0)   begin errors++; $display("[TB] FAIL reset_transmit: got %b, required 0", tr_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, required 0", busy_a); end
        checks++; if (txb_a !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_byte: got %h, required 00", txb_a); end
        checks++; if (err_a !== 8'h00) begin errors++; $display("[TB] FAIL reset_err: got %h, required 00", err_a); end
        checks++; if (ovr_a !== 8'h00) begin errors++; $display("[TB] FAIL reset_ovr: got %h, required 00", ovr_a); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_b: got %b, required 0", busy_b); end
        rst = 1'b0;
        err_exp = 0;
        ovr_exp = 0;
        @(negedge clk);
    endtask

    task automatic test_ping();
        bit ok;
        cap_a.delete();
        send_a(8'h00, 1'b0);
        checks++; if (tr_a !== 1'b0)   begin errors++; $display("[TB] FAIL ping_t1_transmit: got %b, required 0", tr_a); end
        checks++; if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL ping_t1_busy: got %b, required 1", busy_a); end
        @(negedge clk);
        checks++; if (tr_a !== 1'b1)   begin errors++; $display("[TB] FAIL ping_latency: transmit got %b, required 1", tr_a); end
        checks++; if (txb_a !== 8'h55) begin errors++; $display("[TB] FAIL ping_byte: got %h, required 55", txb_a); end
        wait_idle(1'b0, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL ping_idle: busy got %b, required 0", busy_a); end
        checks++; if (cap_a.size() !== 1) begin errors++; $display("[TB] FAIL ping_count: got %0d bytes, required 1", cap_a.size()); end
    endtask

    task automatic test_read_hold();
        bit ok;
        logic [63:0] saved;
        ch_a  = {16'h7777, 16'h3C3C, 16'hBEEF, 16'h0101};
        saved = ch_a;
        cap_a.delete();
        exp_q.delete();
        build_expected(8'h02, saved, NCH_A, DW_A);
        send_a(8'h02, 1'b0);
        for (int i = 0; i < 50 && cap_a.size() == 0; i++) @(negedge clk);
        ch_a = {4{16'h1234}};
        wait_idle(1'b0, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL read_idle: busy got %b, required 0", busy_a); end
        checks++; if (cap_a.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL read_len: got %0d, required %0d", cap_a.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_a.size(); i++) begin
            checks++;
            if (cap_a[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL read_byte%0d: got %h, required %h", i, cap_a[i], exp_q[i]); end
        end
    endtask

    task automatic test_dw12();
        bit ok;
        ch_b = {12'h5A5, 12'hABC};
        cap_b.delete();
        exp_q.delete();
        build_expected(8'h01, 64'(ch_b), NCH_B, DW_B);
        rcv_b = 1'b1;
        rx_b  = 8'h01;
        @(negedge clk);
        rcv_b = 1'b0;
        wait_idle(1'b1, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL dw12_idle: busy got %b, required 0", busy_b); end
        checks++; if (cap_b.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL dw12_len: got %0d, required %0d", cap_b.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_b.size(); i++) begin
            checks++;
            if (cap_b[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL dw12_byte%0d: got %h, required %h", i, cap_b[i], exp_q[i]); end
        end
    endtask

    task automatic test_queue();
        bit ok;
        ch_a = {$urandom, $urandom};
        cap_a.delete();
        exp_q.delete();
        build_expected(8'h03, ch_a, NCH_A, DW_A);
        build_expected(8'h00, ch_a, NCH_A, DW_A);
        send_a(8'h03, 1'b0);
        send_a(8'h00, 1'b0);
        send_a(8'h01, 1'b0);
        ovr_exp++;
        wait_idle(1'b0, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL queue_idle: busy got %b, required 0", busy_a); end
        checks++; if (cap_a.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL queue_len: got %0d, required %0d", cap_a.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_a.size(); i++) begin
            checks++;
            if (cap_a[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL queue_byte%0d: got %h, required %h", i, cap_a[i], exp_q[i]); end
        end
        checks++; if (ovr_a !== 8'(ovr_exp)) begin errors++; $display("[TB] FAIL queue_ovr: got %0d, required %0d", ovr_a, ovr_exp); end
    endtask

    task automatic test_errors();
        bit ok;
        cap_a.delete();
        send_a(8'h07, 1'b0);
        bump_err();
        wait_idle(1'b0, ok);
        checks++; if (cap_a.size() !== 1 || cap_a[0] !== 8'hEE) begin errors++; $display("[TB] FAIL bad_reply: got %0d bytes first %h, required 1 byte EE", cap_a.size(), cap_a[0]); end
        checks++; if (err_a !== 8'(err_exp)) begin errors++; $display("[TB] FAIL bad_err: got %0d, required %0d", err_a, err_exp); end
        cap_a.delete();
        send_a(8'h01, 1'b1);
        bump_err();
        repeat (10) @(negedge clk);
        checks++; if (cap_a.size() !== 0) begin errors++; $display("[TB] FAIL rxerr_reply: got %0d bytes, required 0", cap_a.size()); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL rxerr_busy: got %b, required 0", busy_a); end
        checks++; if (err_a !== 8'(err_exp)) begin errors++; $display("[TB] FAIL rxerr_err: got %0d, required %0d", err_a, err_exp); end
        for (int n = 0; n < 300; n++) begin
            send_a(8'(8'h10 + n[3:0]), 1'b0);
            bump_err();
            wait_idle(1'b0, ok);
        end
        checks++; if (err_a !== 8'(err_exp)) begin errors++; $display("[TB] FAIL err_saturate: got %0d, required %0d", err_a, err_exp); end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        cap_a.delete();
        ch_a = {$urandom, $urandom};
        send_a(8'h02, 1'b0);
        for (int i = 0; i < 50 && cap_a.size() == 0; i++) @(negedge clk);
        for (int i = 0; i < 50 && istx_a; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        err_exp = 0;
        ovr_exp = 0;
        checks++; if (tr_a !== 1'b0)   begin errors++; $display("[TB] FAIL midrst_transmit: got %b, required 0", tr_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b, required 0", busy_a); end
        checks++; if (err_a !== 8'h00) begin errors++; $display("[TB] FAIL midrst_err: got %h, required 00", err_a); end
        checks++; if (ovr_a !== 8'h00) begin errors++; $display("[TB] FAIL midrst_ovr: got %h, required 00", ovr_a); end
        repeat (8) @(negedge clk);
        cap_a.delete();
        send_a(8'h00, 1'b0);
        wait_idle(1'b0, ok);
        checks++; if (cap_a.size() !== 1 || cap_a[0] !== 8'h55) begin errors++; $display("[TB] FAIL midrst_fresh: got %0d bytes first %h, required 1 byte 55", cap_a.size(), cap_a[0]); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [7:0] c;
        int nextra;
        for (int it = 0; it < 25; it++) begin
            ch_a = {$urandom, $urandom};
            cap_a.delete();
            exp_q.delete();
            nextra = $urandom_range(0, 2);
            for (int j = 0; j <= nextra; j++) begin
                c = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 7)) : 8'($urandom);
                send_a(c, 1'b0);
                if (j < 2) begin
                    build_expected(c, ch_a, NCH_A, DW_A);
                    if (is_bad_a(c)) bump_err();
                end else begin
                    ovr_exp++;
                end
            end
            wait_idle(1'b0, ok);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL rand_idle%0d: busy got %b, required 0", it, busy_a); end
            checks++; if (cap_a.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL rand_len%0d: got %0d, required %0d", it, cap_a.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < cap_a.size(); i++) begin
                checks++;
                if (cap_a[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL rand%0d_byte%0d: got %h, required %h", it, i, cap_a[i], exp_q[i]); end
            end
        end
        checks++; if (err_a !== 8'(err_exp)) begin errors++; $display("[TB] FAIL rand_err: got %0d, required %0d", err_a, err_exp); end
        checks++; if (ovr_a !== 8'(ovr_exp)) begin errors++; $display("[TB] FAIL rand_ovr: got %0d, required %0d", ovr_a, ovr_exp); end
    endtask

    initial begin
        $display("[TB] starting wireless_telemetry bench");
        test_reset();
        test_ping();
        test_read_hold();
        test_dw12();
        test_queue();
        test_errors();
        test_reset_midframe();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
